fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Downstream consumer of the branch decision (PCSrc) and the block that sources the next instruction.
- Holds the program counter and issues one instruction-memory fetch at a time over a valid/ready request plus valid response handshake.
- Presents the fetched instruction to decode/execute.
- When execute acknowledges an instruction, computes the next PC from PCSrc and the branch offset, either sequential or taken branch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address and instruction width. Only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  XLEN  fetch address; equals the current PC.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  XLEN  fetched instruction word.
- instr_valid  output  1  instr/instr_pc hold a fetched instruction.
- instr  output  XLEN  instruction word.
- instr_pc  output  XLEN  address of instr.
- instr_ack  input  1  execute consumed instr; PCSrc and ImmExt are valid this cycle.
- PCSrc  input  1  1 = take branch.
- ImmExt  input  XLEN  sign-extended branch offset.
- misaligned  output  1  sticky error: computed target is not 4-byte aligned.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All registers update on the rising edge of clk.
- Reset values: state=S_IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req_valid=0, misaligned=0.
- Reset asserted in any state returns to S_IDLE the next edge. Any outstanding fetch is abandoned. The memory shares the same reset, so no stale response is delivered.
- State machine, states S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR:
  - S_IDLE: all outputs inactive. Moves to S_REQ unconditionally the next cycle, giving one bubble after reset release.
  - S_REQ: imem_req_valid=1 and imem_req_addr=pc. Addr must be stable while valid is high and ready is low. When imem_req_ready=1, move to S_WAIT.
  - S_WAIT: imem_req_valid=0. On imem_rsp_valid=1, capture instr<=imem_rsp_data and instr_pc<=pc, then move to S_HOLD.
  - S_HOLD: instr_valid=1; instr and instr_pc are stable. On instr_ack=1:
    - next = PCSrc ? instr_pc+ImmExt : instr_pc+4.
    - If next[1:0]!=0, set misaligned<=1 and move to S_ERR.
    - Otherwise pc<=next and move to S_REQ.
    - instr_valid drops the cycle after the ack.
  - S_ERR: all handshake outputs 0 and misaligned=1. Stays here until reset.
- imem_rsp_valid is ignored outside S_WAIT. instr_ack is ignored outside S_HOLD.
- PCSrc and ImmExt are sampled only in the S_HOLD cycle where instr_ack=1. An X on PCSrc in any other cycle has no effect.
- Arithmetic is modulo 2^32:
  - pc=0xFFFF_FFFC with a sequential step wraps to 0x0000_0000.
  - A negative ImmExt is two's-complement added.
- Minimum latency:
  - reset release to first imem_req_valid: 1 cycle.
  - req accept to instr_valid: 1 cycle after imem_rsp_valid.
  - ack to next imem_req_valid: 1 cycle.
- The next request address depends only on registered state, so there is no combinational path from the imem inputs to imem_req_addr.

Decomposition:
- Shared package riscv_pkg holds:
  - the fetch_state_t enum (S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR);
  - the XLEN constant;
  - the PC_STEP = 4 constant.
- One sub-module, next_pc_calc: combinational; inputs pc, imm, pcsrc; outputs next and misalign.

Test Plan:
- Reset then imem_req_ready=1 always and a 1-cycle response latency:
  - first imem_req_addr=0x0 one cycle after reset falls;
  - instr_valid with instr_pc=0x0.
- Ack with PCSrc=0 at instr_pc=0x100 -> next imem_req_addr=0x104.
- Ack with PCSrc=1, ImmExt=0xFFFF_FFF8 at instr_pc=0x100 -> next imem_req_addr=0xF8.
- Hold imem_req_ready=0 for 3 cycles in S_REQ -> imem_req_valid and imem_req_addr stay constant; a spurious imem_rsp_valid is ignored.
- Ack with PCSrc=1, ImmExt=0x6 at instr_pc=0x200 -> misaligned=1 next cycle; no further requests; reset clears the error and restarts at RESET_PC.
- pc=0xFFFF_FFFC with a sequential ack -> imem_req_addr=0x0. Separately, assert reset in S_WAIT -> S_IDLE with instr_valid=0, then a fetch from RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
// No logic; no latency; no backpressure.
// Imported by the fetch unit and its next-PC helper.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: sequential step or taken-branch target, plus alignment flag.
// Purely combinational, zero latency.
// No handshake; the caller decides when the result is consumed.
module next_pc_calc
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic            pcsrc,
    output logic [XLEN-1:0] next,
    output logic            misalign
);

    // Both sums wrap modulo 2^XLEN; a negative imm works as two's complement.
    assign next     = pcsrc ? (pc + imm) : (pc + PC_STEP);
    assign misalign = |next[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues one imem request at a time, presents the result.
// Latency: 1 cycle reset->req, 1 cycle rsp->instr_valid, 1 cycle ack->next req.
// Backpressure: request held stable until imem_req_ready; instruction held until instr_ack.
module fetch_unit #(
    parameter int                 XLEN     = 32,
    parameter logic [XLEN-1:0]    RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ack,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    output logic            misaligned
);

    import riscv_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            next_mis;

    next_pc_calc u_next_pc (
        .pc       (instr_pc),
        .imm      (ImmExt),
        .pcsrc    (PCSrc),
        .next     (next_pc),
        .misalign (next_mis)
    );

    // Address comes straight from the PC register: no path from imem inputs.
    assign imem_req_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            instr          <= '0;
            instr_pc       <= '0;
            instr_valid    <= 1'b0;
            imem_req_valid <= 1'b0;
            misaligned     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state          <= S_REQ;
                    imem_req_valid <= 1'b1;
                end
                S_REQ: begin
                    if (imem_req_ready) begin
                        state          <= S_WAIT;
                        imem_req_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr       <= imem_rsp_data;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // PCSrc/ImmExt only matter here, in the ack cycle.
                    if (instr_ack) begin
                        instr_valid <= 1'b0;
                        if (next_mis) begin
                            misaligned <= 1'b1;
                            state      <= S_ERR;
                        end else begin
                            pc             <= next_pc;
                            imem_req_valid <= 1'b1;
                            state          <= S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state          <= S_IDLE;
                    imem_req_valid <= 1'b0;
                    instr_valid    <= 1'b0;
                end
            endcase
        end
    end

endmodule
